alu_muldiv: RTL and testbench
=============================

// Module: alu_muldiv
// PURPOSE
//  Execute-stage ALU, next generation: WIDTH-parametrised single-cycle integer ops plus an
//  iterative multiply/divide unit with architectural HI/LO registers. Single-cycle results
//  are combinational on y. MULT/MULTU/DIV/DIVU run WIDTH cycles behind a start/busy/done
//  handshake. The pipeline stalls EX on busy. Op codes are the `EXE_*_OP` values from defines.vh.
// PARAMETERS
//  WIDTH  32  operand/result width; HI and LO are each WIDTH bits; must be >= 4
// PORTS
//  clk           in   1      clock, rising edge
//  rst           in   1      reset, synchronous, active-high
//  a, b          in   WIDTH  operands (rs, rt/imm already extended)
//  op            in   8      `EXE_*_OP` code
//  start         in   1      issue strobe for MULT/MULTU/DIV/DIVU/MTHI/MTLO
//  flush         in   1      cancel in-flight mul/div (exception/branch flush)
//  y             out  WIDTH  single-cycle result (combinational)
//  overflow      out  1      signed overflow, ADD/ADDI/SUB only (combinational)
//  zero          out  1      y == 0 (combinational)
//  busy          out  1      mul/div in progress
//  done          out  1      1-cycle pulse; HI/LO hold the new result this cycle
//  div_by_zero   out  1      1-cycle pulse with done when divisor was 0
//  hi, lo        out  WIDTH  architectural HI/LO
// BEHAVIOUR
//  - Combinational ops on y:
//    ADD/ADDI/ADDU/LW/SW: a+b.  SUB/SUBU/BEQ: a-b.
//    AND/ANDI, OR/ORI, XOR/XORI, NOR: bitwise.
//    SLT: signed a<b.  SLTU: unsigned a<b.  LUI: {b[15:0], zeros}.
//    MFHI: hi.  MFLO: lo.  Any other op: y=0.
//  - overflow = sign-rule over ADD, ADDI, SUB; 0 for all other ops.
//  - FSM IDLE -> RUN -> DONE -> IDLE. Reset: state=IDLE; hi=lo=0; busy=done=div_by_zero=0.
//  - Accept: state==IDLE && start && op in {MULT,MULTU,DIV,DIVU} && !flush.
//    a/b latched; signed ops latch magnitudes plus result signs. Next state RUN, counter=0.
//  - RUN: one shift-add (mul) or restoring-subtract (div) step per cycle.
//    Exactly WIDTH cycles, then -> DONE. busy=1 throughout RUN and DONE.
//  - DONE (1 cycle): done=1; HI/LO written at the edge entering DONE.
//    Accept at edge 0 -> done high in cycle WIDTH+1. Then -> IDLE; back-to-back accept allowed from IDLE.
//  - MULT/MULTU: {HI,LO} = 2*WIDTH-bit product; sign applied for MULT.
//  - DIV/DIVU: LO = quotient truncated toward 0; HI = remainder, sign of dividend.
//    DIV MIN / -1: LO=MIN, HI=0, no flag.
//  - Divisor 0: full latency, HI/LO unchanged, div_by_zero=1 with done.
//  - MTHI/MTLO: when state==IDLE && start, hi (resp. lo) <= a at that edge. No busy, no done.
//  - start while busy (any op): ignored, no effect on state or HI/LO.
//    start with any other op: ignored.
//  - flush: from RUN or DONE -> IDLE next edge.
//    HI/LO not written if flush arrives in RUN. A DONE-cycle write has already happened and is kept.
//    done is suppressed the cycle after flush. flush wins over a simultaneous start.
//  - rst mid-operation: immediate return to reset values at that edge, including hi/lo.
//  - MFHI/MFLO while busy return the old hi/lo; stalling on busy is the pipeline's job.
// TESTING (WIDTH=32)
//  1. ADD a=32'h7FFFFFFF b=1 -> y=32'h80000000, overflow=1.
//     ADDU same -> overflow=0. SUB 5-5 -> y=0, zero=1.
//  2. MULT a=32'hFFFFFFFE b=3 -> done in cycle 33, HI=32'hFFFFFFFF, LO=32'hFFFFFFFA.
//     MULTU same -> HI=2, LO=32'hFFFFFFFA.
//  3. DIV a=-7 b=2 -> LO=32'hFFFFFFFD, HI=32'hFFFFFFFF. DIVU 7/2 -> LO=3, HI=1.
//  4. DIV b=0 -> done+div_by_zero in cycle 33, HI/LO unchanged.
//     DIV 32'h80000000 / 32'hFFFFFFFF -> LO=32'h80000000, HI=0.
//  5. MULT, then flush in RUN cycle 10 -> busy=0 next cycle, no done, HI/LO unchanged.
//     start DIVU while busy -> ignored.
//  6. rst in RUN -> busy=0, hi=lo=0. MTHI a=32'hA5A5A5A5 -> MFHI gives y=32'hA5A5A5A5 the next cycle.

Source files
------------

// File: rtl/alu_muldiv.sv
// Execute-stage ALU: combinational integer ops on y, plus an iterative multiply/divide unit
// that owns the architectural HI/LO pair. Mul/div issue through start and report busy/done;
// each operation takes WIDTH step cycles followed by one DONE cycle.
module alu_muldiv #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [7:0]       op,
    input  logic             start,
    input  logic             flush,
    output logic [WIDTH-1:0] y,
    output logic             overflow,
    output logic             zero,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    // Operation codes, matching the decode stage's EXE_*_OP values.
    localparam logic [7:0] OP_AND   = 8'b0010_0100;
    localparam logic [7:0] OP_OR    = 8'b0010_0101;
    localparam logic [7:0] OP_XOR   = 8'b0010_0110;
    localparam logic [7:0] OP_NOR   = 8'b0010_0111;
    localparam logic [7:0] OP_ANDI  = 8'b0101_1001;
    localparam logic [7:0] OP_ORI   = 8'b0101_1010;
    localparam logic [7:0] OP_XORI  = 8'b0101_1011;
    localparam logic [7:0] OP_LUI   = 8'b0101_1100;
    localparam logic [7:0] OP_SLT   = 8'b0010_1010;
    localparam logic [7:0] OP_SLTU  = 8'b0010_1011;
    localparam logic [7:0] OP_ADD   = 8'b0010_0000;
    localparam logic [7:0] OP_ADDU  = 8'b0010_0001;
    localparam logic [7:0] OP_SUB   = 8'b0010_0010;
    localparam logic [7:0] OP_SUBU  = 8'b0010_0011;
    localparam logic [7:0] OP_ADDI  = 8'b0101_0101;
    localparam logic [7:0] OP_MULT  = 8'b0001_1000;
    localparam logic [7:0] OP_MULTU = 8'b0001_1001;
    localparam logic [7:0] OP_DIV   = 8'b0001_1010;
    localparam logic [7:0] OP_DIVU  = 8'b0001_1011;
    localparam logic [7:0] OP_MFHI  = 8'b0001_0000;
    localparam logic [7:0] OP_MTHI  = 8'b0001_0001;
    localparam logic [7:0] OP_MFLO  = 8'b0001_0010;
    localparam logic [7:0] OP_MTLO  = 8'b0001_0011;
    localparam logic [7:0] OP_LW    = 8'b1110_0011;
    localparam logic [7:0] OP_SW    = 8'b1110_1011;
    localparam logic [7:0] OP_BEQ   = 8'b0101_0001;

    localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDone
    } state_e;

    state_e state_q, state_d;

    logic [CW-1:0]        cnt_q;
    // Mul: {partial product, multiplier}. Div: {partial remainder, dividend/quotient}.
    logic [2*WIDTH-1:0]   acc_q;
    logic [WIDTH-1:0]     opb_q;    // multiplicand or divisor magnitude
    logic                 div_q;    // operation in flight is a divide
    logic                 neg_q;    // negate product / quotient at the end
    logic                 rneg_q;   // negate remainder at the end (dividend was negative)
    logic                 dbz_q;    // divisor was zero
    logic [WIDTH-1:0]     hi_q, lo_q;

    logic [WIDTH-1:0]     sum, diff, lui_val;
    logic                 is_md_op, sgn_op, div_op, accept, last_step;
    logic [WIDTH-1:0]     mag_a, mag_b;

    logic [WIDTH:0]       mul_sum;
    logic [2*WIDTH-1:0]   mul_next, div_next, step_acc;
    logic [WIDTH:0]       shifted;
    logic                 div_ge;
    logic [WIDTH-1:0]     rem_sub;

    logic [2*WIDTH-1:0]   prod;
    logic [WIDTH-1:0]     quo, rem, res_hi, res_lo;

    assign sum  = a + b;
    assign diff = a - b;

    // Upper-immediate load only makes sense when the word can hold a 16-bit field.
    if (WIDTH >= 16) begin : g_lui_wide
        assign lui_val = WIDTH'(b[15:0]) << (WIDTH - 16);
    end else begin : g_lui_narrow
        assign lui_val = '0;
    end

    // Single-cycle result, signed overflow and zero flag.
    always_comb begin
        y        = '0;
        overflow = 1'b0;
        case (op)
            OP_ADD, OP_ADDI: begin
                y        = sum;
                overflow = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
            end
            OP_ADDU, OP_LW, OP_SW: y = sum;
            OP_SUB: begin
                y        = diff;
                overflow = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SUBU, OP_BEQ:  y = diff;
            OP_AND, OP_ANDI:  y = a & b;
            OP_OR, OP_ORI:    y = a | b;
            OP_XOR, OP_XORI:  y = a ^ b;
            OP_NOR:           y = ~(a | b);
            OP_SLT:           y = {{(WIDTH-1){1'b0}}, $signed(a) < $signed(b)};
            OP_SLTU:          y = {{(WIDTH-1){1'b0}}, a < b};
            OP_LUI:           y = lui_val;
            OP_MFHI:          y = hi_q;
            OP_MFLO:          y = lo_q;
            default:          y = '0;
        endcase
    end

    assign zero = (y == '0);

    // Issue decode and operand magnitudes for the iterative unit.
    always_comb begin
        is_md_op = (op == OP_MULT) || (op == OP_MULTU) || (op == OP_DIV) || (op == OP_DIVU);
        sgn_op   = (op == OP_MULT) || (op == OP_DIV);
        div_op   = (op == OP_DIV) || (op == OP_DIVU);
        accept   = (state_q == StIdle) && start && is_md_op && !flush;
        mag_a    = (sgn_op && a[WIDTH-1]) ? -a : a;
        mag_b    = (sgn_op && b[WIDTH-1]) ? -b : b;
        last_step = (state_q == StRun) && (cnt_q == CNT_LAST);
    end

    // One shift-add or restoring-subtract step on the accumulator.
    always_comb begin
        mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]}
                 + {1'b0, (acc_q[0] ? opb_q : {WIDTH{1'b0}})};
        mul_next = {mul_sum, acc_q[WIDTH-1:1]};
        shifted  = acc_q[2*WIDTH-1:WIDTH-1];
        div_ge   = shifted >= {1'b0, opb_q};
        // When div_ge holds the difference is below the divisor, so the low bits suffice.
        rem_sub  = shifted[WIDTH-1:0] - opb_q;
        div_next = div_ge ? {rem_sub, acc_q[WIDTH-2:0], 1'b1}
                          : {acc_q[2*WIDTH-2:0], 1'b0};
        step_acc = div_q ? div_next : mul_next;
    end

    // Re-apply signs to the final step's magnitudes to form the HI/LO values.
    always_comb begin
        prod   = neg_q ? -step_acc : step_acc;
        quo    = neg_q ? -step_acc[WIDTH-1:0] : step_acc[WIDTH-1:0];
        rem    = rneg_q ? -step_acc[2*WIDTH-1:WIDTH] : step_acc[2*WIDTH-1:WIDTH];
        res_hi = div_q ? rem : prod[2*WIDTH-1:WIDTH];
        res_lo = div_q ? quo : prod[WIDTH-1:0];
    end

    // Next-state logic for the mul/div sequencer; flush always returns to idle.
    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle: if (accept) state_d = StRun;
            StRun: begin
                if (flush)          state_d = StIdle;
                else if (last_step) state_d = StDone;
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Sequencer state, step counter and operand latches.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            acc_q   <= '0;
            opb_q   <= '0;
            div_q   <= 1'b0;
            neg_q   <= 1'b0;
            rneg_q  <= 1'b0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                cnt_q  <= '0;
                acc_q  <= {{WIDTH{1'b0}}, mag_a};
                opb_q  <= mag_b;
                div_q  <= div_op;
                neg_q  <= sgn_op && (a[WIDTH-1] ^ b[WIDTH-1]);
                rneg_q <= sgn_op && div_op && a[WIDTH-1];
                dbz_q  <= div_op && (b == '0);
            end else if (state_q == StRun) begin
                cnt_q <= cnt_q + CW'(1);
                acc_q <= step_acc;
            end
        end
    end

    // HI/LO: result write on the edge into DONE, or a direct move from idle.
    always_ff @(posedge clk) begin
        if (rst) begin
            hi_q <= '0;
            lo_q <= '0;
        end else if (last_step && !flush) begin
            if (!dbz_q) begin
                hi_q <= res_hi;
                lo_q <= res_lo;
            end
        end else if ((state_q == StIdle) && start && !flush) begin
            if (op == OP_MTHI) hi_q <= a;
            if (op == OP_MTLO) lo_q <= a;
        end
    end

    assign busy        = (state_q != StIdle);
    assign done        = (state_q == StDone);
    assign div_by_zero = done && dbz_q;
    assign hi          = hi_q;
    assign lo          = lo_q;

endmodule

// File: tb/tb_alu_muldiv.sv
// Bench for alu_muldiv (WIDTH=32): directed spot checks plus randomized stimulus against a
// plain-arithmetic reference model of the ALU ops and of HI/LO.
module tb_alu_muldiv;

    localparam int W = 32;
    localparam longint SMAX = 2147483647;
    localparam longint SMIN = -SMAX - 1;

    localparam logic [7:0] OP_AND   = 8'b0010_0100;
    localparam logic [7:0] OP_OR    = 8'b0010_0101;
    localparam logic [7:0] OP_XOR   = 8'b0010_0110;
    localparam logic [7:0] OP_NOR   = 8'b0010_0111;
    localparam logic [7:0] OP_ANDI  = 8'b0101_1001;
    localparam logic [7:0] OP_ORI   = 8'b0101_1010;
    localparam logic [7:0] OP_XORI  = 8'b0101_1011;
    localparam logic [7:0] OP_LUI   = 8'b0101_1100;
    localparam logic [7:0] OP_SLT   = 8'b0010_1010;
    localparam logic [7:0] OP_SLTU  = 8'b0010_1011;
    localparam logic [7:0] OP_ADD   = 8'b0010_0000;
    localparam logic [7:0] OP_ADDU  = 8'b0010_0001;
    localparam logic [7:0] OP_SUB   = 8'b0010_0010;
    localparam logic [7:0] OP_SUBU  = 8'b0010_0011;
    localparam logic [7:0] OP_ADDI  = 8'b0101_0101;
    localparam logic [7:0] OP_MULT  = 8'b0001_1000;
    localparam logic [7:0] OP_MULTU = 8'b0001_1001;
    localparam logic [7:0] OP_DIV   = 8'b0001_1010;
    localparam logic [7:0] OP_DIVU  = 8'b0001_1011;
    localparam logic [7:0] OP_MFHI  = 8'b0001_0000;
    localparam logic [7:0] OP_MTHI  = 8'b0001_0001;
    localparam logic [7:0] OP_MFLO  = 8'b0001_0010;
    localparam logic [7:0] OP_MTLO  = 8'b0001_0011;
    localparam logic [7:0] OP_LW    = 8'b1110_0011;
    localparam logic [7:0] OP_SW    = 8'b1110_1011;
    localparam logic [7:0] OP_BEQ   = 8'b0101_0001;

    logic         clk, rst, start, flush;
    logic [W-1:0] a, b;
    logic [7:0]   op;
    logic [W-1:0] y, hi, lo;
    logic         overflow, zero, busy, done, div_by_zero;

    int           total, bad;
    logic [31:0]  exp_hi, exp_lo;
    logic         exp_dbz;

    alu_muldiv #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .a(a), .b(b), .op(op), .start(start), .flush(flush),
        .y(y), .overflow(overflow), .zero(zero), .busy(busy), .done(done),
        .div_by_zero(div_by_zero), .hi(hi), .lo(lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference for the single-cycle ops, using wide signed arithmetic for overflow.
    function automatic void model_alu(input logic [7:0] o, input logic [31:0] x,
                                      input logic [31:0] z, input logic [31:0] h,
                                      input logic [31:0] l, output logic [31:0] ry,
                                      output logic rov);
        longint sx, sz, s;
        sx = longint'($signed(x));
        sz = longint'($signed(z));
        ry = 32'h0;
        rov = 1'b0;
        case (o)
            OP_ADD, OP_ADDI: begin
                s = sx + sz; ry = s[31:0]; rov = (s > SMAX) || (s < SMIN);
            end
            OP_SUB: begin
                s = sx - sz; ry = s[31:0]; rov = (s > SMAX) || (s < SMIN);
            end
            OP_ADDU, OP_LW, OP_SW: ry = x + z;
            OP_SUBU, OP_BEQ:       ry = x - z;
            OP_AND, OP_ANDI:       ry = x & z;
            OP_OR, OP_ORI:         ry = x | z;
            OP_XOR, OP_XORI:       ry = x ^ z;
            OP_NOR:                ry = ~(x | z);
            OP_SLT:                ry = (sx < sz) ? 32'd1 : 32'd0;
            OP_SLTU:               ry = (x < z) ? 32'd1 : 32'd0;
            OP_LUI:                ry = {z[15:0], 16'h0000};
            OP_MFHI:               ry = h;
            OP_MFLO:               ry = l;
            default:               ry = 32'h0;
        endcase
    endfunction

    // Reference for HI/LO after a mul/div; updates exp_hi/exp_lo/exp_dbz.
    task automatic model_md(input logic [7:0] o, input logic [31:0] x, input logic [31:0] z);
        longint sx, sz, q, r;
        logic [63:0] p;
        logic sgn;
        sgn = (o == OP_MULT) || (o == OP_DIV);
        sx = sgn ? longint'($signed(x)) : longint'({32'h0, x});
        sz = sgn ? longint'($signed(z)) : longint'({32'h0, z});
        exp_dbz = 1'b0;
        if (o == OP_MULT || o == OP_MULTU) begin
            p = 64'(sx * sz);
            exp_hi = p[63:32];
            exp_lo = p[31:0];
        end else if (z == 32'h0) begin
            exp_dbz = 1'b1;
        end else begin
            q = sx / sz;
            r = sx % sz;
            exp_lo = q[31:0];
            exp_hi = r[31:0];
        end
    endtask

    // Hold start for exactly one edge, then return the inputs to a neutral state.
    task automatic issue(input logic [7:0] o, input logic [31:0] x, input logic [31:0] z);
        op = o; a = x; b = z; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; op = 8'h00; a = '0; b = '0;
    endtask

    // Advance until done (bounded); cyc numbers the cycle in which done was seen.
    task automatic wait_done(input int c0, output int cyc, output bit busy_ok);
        cyc = c0;
        busy_ok = 1'b1;
        while (done !== 1'b1 && cyc < 200) begin
            if (busy !== 1'b1) busy_ok = 1'b0;
            @(posedge clk); #1;
            cyc++;
        end
        if (busy !== 1'b1) busy_ok = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1; start = 1'b0; flush = 1'b0; op = 8'h00; a = '0; b = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
        total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b want=0", done); end
        total++; if (div_by_zero !== 1'b0) begin
            bad++; $display("FAIL reset_dbz got=%b want=0", div_by_zero);
        end
        total++; if (hi !== 32'h0) begin bad++; $display("FAIL reset_hi got=%h want=0", hi); end
        total++; if (lo !== 32'h0) begin bad++; $display("FAIL reset_lo got=%h want=0", lo); end
        exp_hi = 32'h0; exp_lo = 32'h0; exp_dbz = 1'b0;
    endtask

    task automatic test_alu;
        logic [7:0]  dop[3] = '{OP_ADD, OP_ADDU, OP_SUB};
        logic [31:0] da[3]  = '{32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'd5};
        logic [31:0] db[3]  = '{32'd1, 32'd1, 32'd5};
        logic [31:0] dy[3]  = '{32'h8000_0000, 32'h8000_0000, 32'h0};
        logic        dov[3] = '{1'b1, 1'b0, 1'b0};
        logic        dz[3]  = '{1'b0, 1'b0, 1'b1};
        logic [7:0]  ops[20] = '{OP_ADD, OP_ADDI, OP_ADDU, OP_LW, OP_SW, OP_SUB, OP_SUBU,
                                 OP_BEQ, OP_AND, OP_ANDI, OP_OR, OP_ORI, OP_XOR, OP_XORI,
                                 OP_NOR, OP_SLT, OP_SLTU, OP_LUI, OP_MFLO, 8'hFF};
        logic [31:0] edges[4] = '{32'h7FFF_FFFF, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0};
        logic [31:0] ey;
        logic        eov;
        for (int i = 0; i < 3; i++) begin
            op = dop[i]; a = da[i]; b = db[i];
            #1;
            total++; if (y !== dy[i]) begin
                bad++; $display("FAIL alu_dir%0d_y got=%h want=%h", i, y, dy[i]);
            end
            total++; if (overflow !== dov[i]) begin
                bad++; $display("FAIL alu_dir%0d_ovf got=%b want=%b", i, overflow, dov[i]);
            end
            total++; if (zero !== dz[i]) begin
                bad++; $display("FAIL alu_dir%0d_zero got=%b want=%b", i, zero, dz[i]);
            end
        end
        for (int i = 0; i < 80; i++) begin
            @(posedge clk); #1;
            op = ops[$urandom_range(0, 19)];
            a  = ($urandom_range(0, 3) == 0) ? edges[$urandom_range(0, 3)] : $urandom;
            b  = ($urandom_range(0, 3) == 0) ? edges[$urandom_range(0, 3)] : $urandom;
            if ($urandom_range(0, 7) == 0) b = a;
            #1;
            model_alu(op, a, b, exp_hi, exp_lo, ey, eov);
            total++; if (y !== ey || overflow !== eov || zero !== (ey == 32'h0)) begin
                bad++;
                $display("FAIL alu_rand op=%h a=%h b=%h got y=%h ov=%b z=%b want y=%h ov=%b z=%b",
                         op, a, b, y, overflow, zero, ey, eov, (ey == 32'h0));
            end
        end
        op = 8'h00; a = '0; b = '0;
        @(posedge clk); #1;
    endtask

    task automatic test_muldiv_directed;
        logic [7:0]  mop[6] = '{OP_MULT, OP_MULTU, OP_DIV, OP_DIVU, OP_DIV, OP_DIV};
        logic [31:0] ma[6]  = '{32'hFFFF_FFFE, 32'hFFFF_FFFE, 32'hFFFF_FFF9, 32'd7,
                                32'd1234, 32'h8000_0000};
        logic [31:0] mb[6]  = '{32'd3, 32'd3, 32'd2, 32'd2, 32'd0, 32'hFFFF_FFFF};
        logic [31:0] mh[6]  = '{32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF, 32'd1, 32'd1, 32'h0};
        logic [31:0] ml[6]  = '{32'hFFFF_FFFA, 32'hFFFF_FFFA, 32'hFFFF_FFFD, 32'd3, 32'd3,
                                32'h8000_0000};
        logic        md[6]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        int cyc;
        bit bok;
        for (int i = 0; i < 6; i++) begin
            issue(mop[i], ma[i], mb[i]);
            wait_done(1, cyc, bok);
            total++; if (cyc != W + 1) begin
                bad++; $display("FAIL md_dir%0d_latency got=%0d want=%0d", i, cyc, W + 1);
            end
            total++; if (!bok) begin bad++; $display("FAIL md_dir%0d_busy got=0 want=1", i); end
            total++; if (hi !== mh[i] || lo !== ml[i] || div_by_zero !== md[i]) begin
                bad++;
                $display("FAIL md_dir%0d got hi=%h lo=%h dbz=%b want hi=%h lo=%h dbz=%b",
                         i, hi, lo, div_by_zero, mh[i], ml[i], md[i]);
            end
            @(posedge clk); #1;
            total++; if (done !== 1'b0 || busy !== 1'b0 || div_by_zero !== 1'b0) begin
                bad++;
                $display("FAIL md_dir%0d_after got done=%b busy=%b dbz=%b want 0 0 0",
                         i, done, busy, div_by_zero);
            end
            exp_hi = mh[i]; exp_lo = ml[i];
        end
    endtask

    task automatic test_flush;
        int cyc;
        bit bok, seen;
        logic [31:0] x, z;
        issue(OP_MULT, 32'd12345, 32'd678);
        repeat (9) begin @(posedge clk); #1; end
        op = OP_MFHI;
        #1;
        total++; if (y !== exp_hi) begin
            bad++; $display("FAIL mfhi_busy got=%h want=%h", y, exp_hi);
        end
        op = 8'h00;
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL flush_busy got=%b want=0", busy); end
        seen = 1'b0;
        repeat (40) begin
            if (done === 1'b1) seen = 1'b1;
            @(posedge clk); #1;
        end
        total++; if (seen) begin bad++; $display("FAIL flush_done got=1 want=0"); end
        total++; if (hi !== exp_hi || lo !== exp_lo) begin
            bad++; $display("FAIL flush_hilo got=%h/%h want=%h/%h", hi, lo, exp_hi, exp_lo);
        end
        // Starts while busy must be ignored.
        x = $urandom; z = $urandom;
        issue(OP_MULT, x, z);
        repeat (5) begin @(posedge clk); #1; end
        issue(OP_DIVU, 32'd100, 32'd7);
        issue(OP_MTLO, 32'hDEAD_BEEF, 32'd0);
        wait_done(8, cyc, bok);
        model_md(OP_MULT, x, z);
        total++; if (cyc != W + 1) begin
            bad++; $display("FAIL busy_start_latency got=%0d want=%0d", cyc, W + 1);
        end
        total++; if (hi !== exp_hi || lo !== exp_lo) begin
            bad++; $display("FAIL busy_start_hilo got=%h/%h want=%h/%h", hi, lo, exp_hi, exp_lo);
        end
        @(posedge clk); #1;
        total++; if (busy !== 1'b0) begin
            bad++; $display("FAIL busy_start_idle got=%b want=0", busy);
        end
    endtask

    task automatic test_reset_mid;
        issue(OP_MTHI, 32'h1234_5678, 32'd0);
        issue(OP_MTLO, 32'h9ABC_DEF0, 32'd0);
        total++; if (hi !== 32'h1234_5678 || lo !== 32'h9ABC_DEF0 || busy !== 1'b0) begin
            bad++; $display("FAIL mtx got hi=%h lo=%h busy=%b want 12345678 9abcdef0 0",
                            hi, lo, busy);
        end
        issue(OP_MULT, 32'd3, 32'd5);
        repeat (4) begin @(posedge clk); #1; end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        total++; if (busy !== 1'b0 || done !== 1'b0 || hi !== 32'h0 || lo !== 32'h0) begin
            bad++; $display("FAIL rst_mid got busy=%b done=%b hi=%h lo=%h want 0 0 0 0",
                            busy, done, hi, lo);
        end
        exp_hi = 32'h0; exp_lo = 32'h0;
        issue(OP_MTHI, 32'hA5A5_A5A5, 32'd0);
        exp_hi = 32'hA5A5_A5A5;
        op = OP_MFHI;
        #1;
        total++; if (y !== 32'hA5A5_A5A5 || busy !== 1'b0) begin
            bad++; $display("FAIL mthi_mfhi got y=%h busy=%b want a5a5a5a5 0", y, busy);
        end
        op = 8'h00;
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back;
        logic [7:0] mops[4] = '{OP_MULT, OP_MULTU, OP_DIV, OP_DIVU};
        logic [7:0] o;
        logic [31:0] x, z;
        int cyc;
        bit bok;
        for (int i = 0; i < 24; i++) begin
            o = mops[$urandom_range(0, 3)];
            x = $urandom;
            z = $urandom;
            case ($urandom_range(0, 7))
                0: z = 32'h0;
                1: begin x = 32'h8000_0000; z = 32'hFFFF_FFFF; end
                2: z = $urandom_range(1, 20);
                3: x = $urandom_range(0, 100);
                default: ;
            endcase
            issue(o, x, z);
            wait_done(1, cyc, bok);
            model_md(o, x, z);
            total++; if (cyc != W + 1 || !bok) begin
                bad++; $display("FAIL b2b%0d_timing got cyc=%0d busy_ok=%0d want %0d 1",
                                i, cyc, bok, W + 1);
            end
            total++; if (hi !== exp_hi || lo !== exp_lo || div_by_zero !== exp_dbz) begin
                bad++;
                $display("FAIL b2b%0d op=%h a=%h b=%h got hi=%h lo=%h dbz=%b want %h %h %b",
                         i, o, x, z, hi, lo, div_by_zero, exp_hi, exp_lo, exp_dbz);
            end
            @(posedge clk); #1;
        end
    endtask

    initial begin
        total = 0;
        bad = 0;
        test_reset();
        test_alu();
        test_muldiv_directed();
        test_flush();
        test_reset_mid();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1, "timeout");
    end

endmodule
